// File: rtl/fir_seq_pkg.sv
// Shared types, default widths and tap-index arithmetic for the FIR tap sequencer.
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    OUTPUT  = 2'd3
  } seq_state_e;

  localparam int TAPS_DEF     = 8;
  localparam int INT_IN_DEF   = 1;
  localparam int FRAC_IN_DEF  = 11;
  localparam int INT_OUT_DEF  = 10;
  localparam int FRAC_OUT_DEF = 22;
  localparam int IN_W_DEF     = INT_IN_DEF + FRAC_IN_DEF;
  localparam int OUT_W_DEF    = INT_OUT_DEF + FRAC_OUT_DEF;

  // wptr is the slot the next sample will land in, so the newest sample sits at wptr-1.
  function automatic int unsigned tap_index(int unsigned wptr, int unsigned offset,
                                            int unsigned taps);
    return (wptr + 2 * taps - 1 - offset) % taps;
  endfunction

endpackage

// File: rtl/sample_ring.sv
// Circular delay line: one write port at a wrapping pointer, one read port addressed
// by age (0 = newest). A read in the same cycle as a write already sees the new sample.
module sample_ring
  import fir_seq_pkg::*;
#(
  parameter int taps_p  = 8,
  parameter int width_p = 12,
  localparam int addr_w = $clog2(taps_p)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [width_p-1:0] wr_data,
  input  logic [addr_w-1:0]  rd_offset,
  output logic [width_p-1:0] rd_data
);

  logic [width_p-1:0] line [taps_p];
  logic [addr_w-1:0]  wptr;
  logic [addr_w-1:0]  wptr_next;
  logic [addr_w-1:0]  rd_idx;

  assign wptr_next = wr_en ? wptr + 1'b1 : wptr;
  assign rd_idx    = addr_w'(tap_index(32'(wptr_next), 32'(rd_offset), taps_p));
  assign rd_data   = (wr_en && rd_idx == wptr) ? wr_data : line[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      for (int i = 0; i < taps_p; i++) line[i] <= '0;
    end else if (wr_en) begin
      line[wptr] <= wr_data;
      wptr       <= wptr_next;
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Feeds (sample, coefficient) pairs to a never-clearing MAC and reports each pass as the
// accumulator delta. Define FIR_ZERO_SKIP_EN to skip taps whose coefficient is zero.
module fir_tap_sequencer
  import fir_seq_pkg::*;
#(
  parameter int taps_p     = TAPS_DEF,
  parameter int int_in_p   = INT_IN_DEF,
  parameter int frac_in_p  = FRAC_IN_DEF,
  parameter int int_out_p  = INT_OUT_DEF,
  parameter int frac_out_p = FRAC_OUT_DEF,
  localparam int in_w      = int_in_p + frac_in_p,
  localparam int out_w     = int_out_p + frac_out_p,
  localparam int addr_w    = $clog2(taps_p)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [in_w-1:0]   sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  input  logic              coef_we_i,
  input  logic [addr_w-1:0] coef_addr_i,
  input  logic [in_w-1:0]   coef_data_i,
  output logic [in_w-1:0]   mac_a_o,
  output logic [in_w-1:0]   mac_b_o,
  output logic              mac_valid_o,
  input  logic              mac_ready_i,
  input  logic [out_w-1:0]  mac_data_i,
  input  logic              mac_valid_i,
  output logic              mac_ready_o,
  output logic [out_w-1:0]  y_o,
  output logic              y_valid_o,
  input  logic              y_ready_i
);

  localparam logic [addr_w-1:0] last_k = addr_w'(taps_p - 1);

  seq_state_e        state, state_next;
  logic [addr_w-1:0] k, k_next;
  logic [in_w-1:0]   coef [taps_p];
  logic [in_w-1:0]   op_a, op_b;
  logic [in_w-1:0]   ring_rd, coef_rd;
  logic [out_w-1:0]  y_q, base_q;
  logic              accept, load_op, issue_valid, y_load, y_zero, pass_done;

  assign accept = sample_valid_i && (state == IDLE);

  sample_ring #(
    .taps_p (taps_p),
    .width_p(in_w)
  ) u_ring (
    .clk      (clk_i),
    .rst_n    (reset_i),
    .wr_en    (accept),
    .wr_data  (sample_i),
    .rd_offset(k_next),
    .rd_data  (ring_rd)
  );

  // Operands are captured when a tap is entered, so coefficient writes during a stall
  // cannot disturb a pair already presented to the MAC.
  assign coef_rd = (coef_we_i && coef_addr_i == k_next) ? coef_data_i : coef[k_next];

`ifdef FIR_ZERO_SKIP_EN
  logic more_nonzero;
  always_comb begin
    more_nonzero = 1'b0;
    for (int i = 0; i < taps_p; i++)
      if (i > int'(k) && coef[i] != '0) more_nonzero = 1'b1;
  end
  assign pass_done = (k == last_k) || !more_nonzero;
`else
  assign pass_done = (k == last_k);
`endif

  always_comb begin
    state_next  = state;
    k_next      = k;
    issue_valid = 1'b0;
    y_load      = 1'b0;
    y_zero      = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid_i) begin
          state_next = ISSUE;
          k_next     = '0;
        end
      end
      ISSUE: begin
`ifdef FIR_ZERO_SKIP_EN
        if (op_b == '0) begin
          if (k == last_k) begin
            state_next = OUTPUT;
            y_zero     = 1'b1;
          end else begin
            k_next = k + 1'b1;
          end
        end else
`endif
        begin
          issue_valid = 1'b1;
          if (mac_ready_i) state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (mac_valid_i) begin
          if (pass_done) begin
            state_next = OUTPUT;
            y_load     = 1'b1;
          end else begin
            k_next     = k + 1'b1;
            state_next = ISSUE;
          end
        end
      end
      OUTPUT: begin
        if (y_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_op = (state_next == ISSUE) && !((state == ISSUE) && (k_next == k));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state  <= IDLE;
      k      <= '0;
      op_a   <= '0;
      op_b   <= '0;
      y_q    <= '0;
      base_q <= '0;
      for (int i = 0; i < taps_p; i++) coef[i] <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
      if (coef_we_i) coef[coef_addr_i] <= coef_data_i;
      if (load_op) begin
        op_a <= ring_rd;
        op_b <= coef_rd;
      end
      // Modular subtraction keeps the per-pass delta exact across accumulator wrap.
      if (y_load) begin
        y_q    <= mac_data_i - base_q;
        base_q <= mac_data_i;
      end else if (y_zero) begin
        y_q <= '0;
      end
    end
  end

  assign sample_ready_o = (state == IDLE);
  assign mac_valid_o    = issue_valid;
  assign mac_a_o        = op_a;
  assign mac_b_o        = op_b;
  assign mac_ready_o    = (state == COLLECT) && mac_valid_i;
  assign y_o            = y_q;
  assign y_valid_o      = (state == OUTPUT);

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Drives the shared mac block from the producer side, turning one accepted audio sample into a full FIR pass for the tuner front end. Keeps a circular delay line of the last taps_p samples and a coefficient register file. Streams (sample, coefficient) pairs to the MAC over valid/ready and consumes each partial result. Because the MAC accumulator never clears, the filter output is the difference between the final accumulator value of this pass and that of the previous pass.

Parameters:
taps_p, 8, number of FIR taps (power of 2, 2..64)
int_in_p, 1, integer bits of sample/coefficient (signed fixed point)
frac_in_p, 11, fractional bits of sample/coefficient
int_out_p, 10, integer bits of accumulator/output
frac_out_p, 22, fractional bits of accumulator/output

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; asynchronous, active-low
sample_i  in  int_in_p+frac_in_p  new input sample
sample_valid_i  in  1  sample valid
sample_ready_o  out  1  sequencer ready for a sample
coef_we_i  in  1  coefficient write strobe
coef_addr_i  in  $clog2(taps_p)  coefficient index
coef_data_i  in  int_in_p+frac_in_p  coefficient value
mac_a_o  out  int_in_p+frac_in_p  sample operand to MAC
mac_b_o  out  int_in_p+frac_in_p  coefficient operand to MAC
mac_valid_o  out  1  operand pair valid
mac_ready_i  in  1  MAC ready for operands
mac_data_i  in  int_out_p+frac_out_p  MAC accumulator value
mac_valid_i  in  1  MAC result valid
mac_ready_o  out  1  sequencer consumes MAC result
y_o  out  int_out_p+frac_out_p  filter output
y_valid_o  out  1  output valid
y_ready_i  in  1  downstream ready

Behaviour:
- Reset: state IDLE, write pointer 0, tap index 0, delay line 0, coefficients 0, base 0. All outputs 0 except sample_ready_o=1. The MAC shares this reset net, so base and accumulator stay consistent.
- IDLE: sample_ready_o=1. Handshake occurs when sample_valid_i&&sample_ready_o:
  - write the sample at wptr; wptr increments mod taps_p (wraps taps_p-1 -> 0);
  - k=0; go to ISSUE.
- ISSUE:
  - mac_valid_o=1, mac_a_o=delay[(newest-k) mod taps_p], mac_b_o=coef[k].
  - Operands are held stable until mac_ready_i, then go to COLLECT.
- COLLECT: mac_ready_o = mac_valid_i (combinational). On mac_valid_i:
  - if k==taps_p-1: y <= mac_data_i - base; base <= mac_data_i; go to OUTPUT;
  - else k++; go to ISSUE.
- OUTPUT: y_valid_o=1 with y_o held stable until y_ready_i, then go to IDLE. y_valid_o does not depend on y_ready_i.
- Latency: minimum 2*taps_p+2 cycles from sample accept to y_valid_o, when the MAC answers on the next cycle.
- Subtraction is two's-complement modulo 2^(int_out_p+frac_out_p), so accumulator wrap-around still yields the correct per-pass delta. No saturation.
- Coefficient writes are accepted in any state and take effect at the next read of that index. Last write wins.
- No new sample is accepted outside IDLE.
- Asserting reset in any state returns to IDLE immediately, and the partial pass is discarded.

Optional Feature:
FIR_ZERO_SKIP_EN:
- Defined: taps whose coefficient is exactly 0 are not issued. k advances over them in ISSUE at 1 cycle per skipped tap, with mac_valid_o=0.
- If the last nonzero tap completes in COLLECT, the pass finishes there.
- If all coefficients are 0, the sequencer goes from ISSUE straight to OUTPUT with y=0, and base is unchanged.
- Undefined: every tap is issued regardless of value.

Decomposition:
- Package fir_seq_pkg holds:
  - state enum (IDLE, ISSUE, COLLECT, OUTPUT);
  - width localparams derived from int/frac params;
  - a helper function for modular tap index.
- One natural sub-module, sample_ring: delay line with circular write pointer and read-by-offset port.

Test Plan:
1. Load coef[0]=12'h400 (0.5), others 0; send sample 12'h400 (0.5) -> y_o=32'h0010_0000 (0.25), y_valid_o after 18 cycles with MAC ready.
2. Load coef[1]=12'h400 only; send 12'h400 then 12'h000 -> outputs 0, then 32'h0010_0000 (one-sample delay).
3. Send 9 samples of 12'h400 with coef[0..7]=12'h400 -> first pass 0.25, eighth and ninth pass 2.0 (32'h0080_0000), confirming pointer wrap.
4. Hold y_ready_i=0 for 20 cycles and assert sample_valid_i -> y_o stable, sample_ready_o=0, and no sample is lost once released.
5. Preload the MAC accumulator near +max via a prior pass sequence so it wraps -> y_o still equals the exact per-pass delta.
6. Assert reset_i low mid-ISSUE (k=3) -> outputs go to reset values asynchronously; the next pass after release matches the fresh-reset result.
